sp_xmem_sram: RTL and testbench

- Downstream consumer of the support processor's xmem port (32-bit big-endian classic Wishbone, word addressed).
- Converts each xmem word access into one or two accesses on an external 16-bit asynchronous SRAM/PSRAM.
- Wait states are programmable by parameter, and halfwords with no selected bytes are skipped.
- Sits between the SP memory subsystem and the board memory pins.

---
 rtl/sp_xmem_sram_if.sv | 15 +
 rtl/sp_xmem_sram.sv | 183 ++++++++++++++++++
 tb/tb_sp_xmem_sram.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sp_xmem_sram_if.sv
// Support-processor xmem bus: 32-bit big-endian classic Wishbone, word addressed.
// The master drives the request; the slave returns read data and a one-cycle ack.
interface sp_xmem_sram_if;
  logic [2:31] adr;
  logic [0:31] wdata;
  logic [0:31] rdata;
  logic        we;
  logic [0:3]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (output adr, wdata, we, sel, stb, cyc, input rdata, ack);
  modport slave  (input adr, wdata, we, sel, stb, cyc, output rdata, ack);
endinterface

// File: rtl/sp_xmem_sram.sv
// Bridges xmem word accesses onto a 16-bit async SRAM/PSRAM as one or two halfword
// strobes with programmable width; every output is registered from next-state logic.
module sp_xmem_sram #(
  parameter int ADDR_WIDTH  = 19,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sp_xmem_sram_if.slave         xmem,
  output logic [ADDR_WIDTH-1:0] mem_a,
  input  logic [0:15]           mem_dq_in,
  output logic [0:15]           mem_dq_out,
  output logic                  mem_dq_oe,
  output logic                  mem_ce_n,
  output logic                  mem_oe_n,
  output logic                  mem_we_n,
  output logic [0:1]            mem_be_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, ACK} state_t;

  state_t                  state, state_nxt;
  logic                    half, half_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    abort, abort_nxt;
  logic [33-ADDR_WIDTH:31] adr_q, adr_nxt;
  logic [0:31]             wdata_q, wdata_nxt;
  logic [0:31]             rdata_q, rdata_nxt;
  logic [0:31]             dat_q, dat_nxt;
  logic [0:3]              sel_q, sel_nxt;
  logic                    we_q, we_nxt;
  logic                    ack_q, ack_nxt;
  logic [ADDR_WIDTH-1:0]   a_nxt;
  logic [0:15]             dq_out_nxt;
  logic                    dq_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;
  logic [0:1]              be_n_nxt;
  logic [0:1]              pair_sel;

  // Word address bits above the memory size alias onto the same locations.
  logic unused_adr;
  assign unused_adr = ^xmem.adr[2:32-ADDR_WIDTH];

  assign xmem.rdata = dat_q;
  assign xmem.ack   = ack_q;

  always_comb begin
    state_nxt  = state;
    half_nxt   = half;
    cnt_nxt    = cnt;
    abort_nxt  = abort;
    adr_nxt    = adr_q;
    wdata_nxt  = wdata_q;
    rdata_nxt  = rdata_q;
    dat_nxt    = dat_q;
    sel_nxt    = sel_q;
    we_nxt     = we_q;
    ack_nxt    = 1'b0;
    a_nxt      = mem_a;
    dq_out_nxt = mem_dq_out;
    dq_oe_nxt  = 1'b0;
    ce_n_nxt   = 1'b1;
    oe_n_nxt   = 1'b1;
    we_n_nxt   = 1'b1;
    be_n_nxt   = 2'b11;
    pair_sel   = 2'b00;

    case (state)
      IDLE: begin
        if (xmem.cyc && xmem.stb && !ack_q) begin
          adr_nxt   = xmem.adr[33-ADDR_WIDTH:31];
          wdata_nxt = xmem.wdata;
          sel_nxt   = xmem.sel;
          we_nxt    = xmem.we;
          rdata_nxt = '0;
          abort_nxt = 1'b0;
          cnt_nxt   = 4'(WAIT_CYCLES);
          if (xmem.sel[0:1] != 2'b00) begin
            state_nxt = ACCESS;
            half_nxt  = 1'b0;
          end else if (xmem.sel[2:3] != 2'b00) begin
            state_nxt = ACCESS;
            half_nxt  = 1'b1;
          end else begin
            state_nxt = ACK;
            dat_nxt   = '0;
          end
        end
      end
      ACCESS: begin
        // Dropping cyc truncates the strobe; the read data is not captured then.
        if (!xmem.cyc) begin
          state_nxt = RECOVER;
          abort_nxt = 1'b1;
        end else if (cnt == 4'd0) begin
          state_nxt = RECOVER;
          if (!we_q) begin
            if (half) rdata_nxt[16:31] = mem_dq_in;
            else      rdata_nxt[0:15]  = mem_dq_in;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RECOVER: begin
        if (abort || !xmem.cyc) begin
          state_nxt = IDLE;
        end else if (!half && sel_q[2:3] != 2'b00) begin
          state_nxt = ACCESS;
          half_nxt  = 1'b1;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end else begin
          state_nxt = ACK;
          dat_nxt   = rdata_q;
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Pin values follow the state being entered, so the pins line up with the state.
    case (state_nxt)
      ACCESS: begin
        pair_sel = half_nxt ? sel_nxt[2:3] : sel_nxt[0:1];
        a_nxt    = {adr_nxt, half_nxt};
        ce_n_nxt = 1'b0;
        be_n_nxt = ~pair_sel;
        if (we_nxt) begin
          we_n_nxt   = 1'b0;
          dq_oe_nxt  = 1'b1;
          dq_out_nxt = half_nxt ? wdata_nxt[16:31] : wdata_nxt[0:15];
        end else begin
          oe_n_nxt = 1'b0;
        end
      end
      RECOVER: dq_oe_nxt = we_q;
      ACK:     ack_nxt   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      half       <= 1'b0;
      cnt        <= 4'd0;
      abort      <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      mem_a      <= '0;
      mem_dq_out <= '0;
      mem_dq_oe  <= 1'b0;
      mem_ce_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
      mem_be_n   <= 2'b11;
    end else begin
      state      <= state_nxt;
      half       <= half_nxt;
      cnt        <= cnt_nxt;
      abort      <= abort_nxt;
      adr_q      <= adr_nxt;
      wdata_q    <= wdata_nxt;
      rdata_q    <= rdata_nxt;
      dat_q      <= dat_nxt;
      sel_q      <= sel_nxt;
      we_q       <= we_nxt;
      ack_q      <= ack_nxt;
      mem_a      <= a_nxt;
      mem_dq_out <= dq_out_nxt;
      mem_dq_oe  <= dq_oe_nxt;
      mem_ce_n   <= ce_n_nxt;
      mem_oe_n   <= oe_n_nxt;
      mem_we_n   <= we_n_nxt;
      mem_be_n   <= be_n_nxt;
    end
  end

endmodule

// File: tb/tb_sp_xmem_sram.sv
// Directed bench for sp_xmem_sram: instance A uses WAIT_CYCLES=1/ADDR_WIDTH=19,
// instance B uses WAIT_CYCLES=0/ADDR_WIDTH=12 for zero-wait and aliasing cases.
module tb_sp_xmem_sram;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        target;
  logic [2:31] adr;
  logic [0:31] wdata;
  logic [0:3]  sel;
  logic        we, stb, cyc;
  logic [0:15] loVal, hiVal;

  sp_xmem_sram_if busA ();
  sp_xmem_sram_if busB ();

  assign busA.adr = adr;  assign busA.wdata = wdata;  assign busA.sel = sel;  assign busA.we = we;
  assign busA.stb = stb && !target;  assign busA.cyc = cyc && !target;
  assign busB.adr = adr;  assign busB.wdata = wdata;  assign busB.sel = sel;  assign busB.we = we;
  assign busB.stb = stb && target;   assign busB.cyc = cyc && target;

  logic [18:0] aA;
  logic [11:0] aB;
  logic [0:15] dqInA, dqInB, dqOutA, dqOutB;
  logic        dqOeA, dqOeB, ceA, ceB, oeA, oeB, weA, weB;
  logic [0:1]  beA, beB;

  assign dqInA = aA[0] ? hiVal : loVal;
  assign dqInB = aB[0] ? hiVal : loVal;

  sp_xmem_sram #(.ADDR_WIDTH(19), .WAIT_CYCLES(1)) dutA (
    .clk(clk), .reset(reset), .xmem(busA), .mem_a(aA), .mem_dq_in(dqInA),
    .mem_dq_out(dqOutA), .mem_dq_oe(dqOeA), .mem_ce_n(ceA), .mem_oe_n(oeA),
    .mem_we_n(weA), .mem_be_n(beA));

  sp_xmem_sram #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .reset(reset), .xmem(busB), .mem_a(aB), .mem_dq_in(dqInB),
    .mem_dq_out(dqOutB), .mem_dq_oe(dqOeB), .mem_ce_n(ceB), .mem_oe_n(oeB),
    .mem_we_n(weB), .mem_be_n(beB));

  // Observed pins of whichever instance is currently targeted.
  logic [31:0] aObs, dqObs, datObs, beObs;
  logic        ackObs, ceObs, oeObs, weObs, dqOeObs;
  always_comb begin
    aObs = 32'(aA); dqObs = 32'(dqOutA); datObs = busA.rdata; beObs = 32'(beA);
    ackObs = busA.ack; ceObs = ceA; oeObs = oeA; weObs = weA; dqOeObs = dqOeA;
    if (target) begin
      aObs = 32'(aB); dqObs = 32'(dqOutB); datObs = busB.rdata; beObs = 32'(beB);
      ackObs = busB.ack; ceObs = ceB; oeObs = oeB; weObs = weB; dqOeObs = dqOeB;
    end
  end

  int checks = 0;
  int errors = 0;
  int ackCnt, ceLowCnt;

  bit          expWeN [1:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  bit          expDqOe[1:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] expAdr [1:7] = '{32'h20, 32'h20, 32'h20, 32'h21, 32'h21, 32'h21, 32'h21};
  logic [31:0] expDq  [1:7] = '{32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hBEEF, 32'hBEEF, 32'hBEEF, 32'hBEEF};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic t, input logic [29:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic w);
    target = t; adr = a; wdata = d; sel = s; we = w;
    stb = 1'b1; cyc = 1'b1;
  endtask

  task automatic releaseBus();
    stb = 1'b0; cyc = 1'b0;
  endtask

  initial begin
    reset = 1'b1; target = 1'b0; adr = '0; wdata = '0; sel = 4'hF; we = 1'b1;
    stb = 1'b1; cyc = 1'b1; loVal = '0; hiVal = '0;
    repeat (3) nextCycle();
    checkOutput("rst ce_n", 32'(ceObs), 32'd1);
    checkOutput("rst we_n", 32'(weObs), 32'd1);
    checkOutput("rst oe_n", 32'(oeObs), 32'd1);
    checkOutput("rst be_n", beObs, 32'd3);
    checkOutput("rst dq_oe", 32'(dqOeObs), 32'd0);
    checkOutput("rst ack", 32'(ackObs), 32'd0);
    releaseBus();
    reset = 1'b0;
    ackCnt = 0;
    repeat (5) begin nextCycle(); if (ackObs) ackCnt++; end
    checkOutput("post-rst acks", 32'(ackCnt), 32'd0);

    // Full-word write, one wait state.
    applyStimulus(1'b0, 30'h10, 32'hDEADBEEF, 4'b1111, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      nextCycle();
      checkOutput($sformatf("wr c%0d we_n", c), 32'(weObs), 32'(expWeN[c]));
      checkOutput($sformatf("wr c%0d dq_oe", c), 32'(dqOeObs), 32'(expDqOe[c]));
      checkOutput($sformatf("wr c%0d mem_a", c), aObs, expAdr[c]);
      checkOutput($sformatf("wr c%0d dq", c), dqObs, expDq[c]);
      checkOutput($sformatf("wr c%0d ack", c), 32'(ackObs), 32'(c == 7));
    end
    releaseBus();
    nextCycle();
    checkOutput("wr ack single", 32'(ackObs), 32'd0);

    // Single byte read from the odd halfword.
    loVal = 16'hAAAA; hiVal = 16'h1234;
    applyStimulus(1'b0, 30'h5, 32'h0, 4'b0010, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      checkOutput($sformatf("byte c%0d ack", c), 32'(ackObs), 32'(c == 4));
      checkOutput($sformatf("byte c%0d ce_n", c), 32'(ceObs), 32'(c > 2));
    end
    releaseBus();
    checkOutput("byte dat", datObs, 32'h00001234);
    nextCycle();

    // No bytes selected: immediate ack, zero data, no memory strobe.
    applyStimulus(1'b0, 30'h7, 32'h0, 4'b0000, 1'b0);
    nextCycle();
    checkOutput("sel0 ack", 32'(ackObs), 32'd1);
    checkOutput("sel0 ce_n", 32'(ceObs), 32'd1);
    checkOutput("sel0 dat", datObs, 32'h0);
    releaseBus();
    nextCycle();

    // Zero-wait full-word read on instance B, stb held for a back-to-back request.
    loVal = 16'hCAFE; hiVal = 16'hF00D;
    applyStimulus(1'b1, 30'h3, 32'h0, 4'b1111, 1'b0);
    nextCycle();
    checkOutput("w0 c1 mem_a", aObs, 32'h6);
    checkOutput("w0 c1 oe_n", 32'(oeObs), 32'd0);
    checkOutput("w0 c1 be_n", beObs, 32'd0);
    checkOutput("w0 c1 dq_oe", 32'(dqOeObs), 32'd0);
    nextCycle();
    nextCycle();
    checkOutput("w0 c3 mem_a", aObs, 32'h7);
    nextCycle();
    checkOutput("w0 c4 ack", 32'(ackObs), 32'd0);
    nextCycle();
    checkOutput("w0 c5 ack", 32'(ackObs), 32'd1);
    checkOutput("w0 dat", datObs, 32'hCAFEF00D);
    nextCycle();
    checkOutput("w0 c6 ack", 32'(ackObs), 32'd0);
    checkOutput("w0 c6 ce_n", 32'(ceObs), 32'd1);
    nextCycle();
    checkOutput("w0 c7 ce_n", 32'(ceObs), 32'd0);
    releaseBus();
    ackCnt = 0;
    repeat (4) begin nextCycle(); if (ackObs) ackCnt++; end
    checkOutput("w0 abort acks", 32'(ackCnt), 32'd0);

    // Address bit 12 lies above an 11-bit word address and must alias to 0.
    applyStimulus(1'b1, 30'h1000, 32'h0, 4'b1100, 1'b0);
    nextCycle();
    checkOutput("alias mem_a", aObs, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("alias ack", 32'(ackObs), 32'd1);
    releaseBus();
    nextCycle();

    // Abort a write in its first strobe cycle.
    applyStimulus(1'b0, 30'h40, 32'h11112222, 4'b1111, 1'b1);
    nextCycle();
    checkOutput("abort c1 we_n", 32'(weObs), 32'd0);
    releaseBus();
    nextCycle();
    checkOutput("abort c2 we_n", 32'(weObs), 32'd1);
    ackCnt = 0; ceLowCnt = 0;
    repeat (6) begin
      if (ackObs) ackCnt++;
      if (!ceObs) ceLowCnt++;
      nextCycle();
    end
    checkOutput("abort acks", 32'(ackCnt), 32'd0);
    checkOutput("abort ce cycles", 32'(ceLowCnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
